// File: rtl/sort_unpacker_if.sv
// sort_unpacker_if: packed-frame input and element-stream output of sort_unpacker.
interface sort_unpacker_if #(
  parameter int NUM_VALS = 9,
  parameter int SIZE = 8
);
  localparam int IW = $clog2(NUM_VALS) < 1 ? 1 : $clog2(NUM_VALS);
  logic in_valid;
  logic in_ready;
  logic [NUM_VALS*SIZE-1:0] in_bus;
  logic out_valid;
  logic out_ready;
  logic [SIZE-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic out_first;
  logic out_last;
  logic out_order_err;
  logic order_err_sticky;
  modport master (
    output in_valid, in_bus, out_ready,
    input in_ready, out_valid, out_data, out_idx, out_first, out_last, out_order_err, order_err_sticky
  );
  modport slave (
    input in_valid, in_bus, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_first, out_last, out_order_err, order_err_sticky
  );
endinterface

// File: rtl/sort_unpacker.sv
// sort_unpacker: serialises a descending-sorted packed frame, flagging out-of-order elements.
module sort_unpacker #(
  parameter int NUM_VALS = 9,
  parameter int SIZE = 8
) (
  input logic clk,
  input logic rst_n,
  sort_unpacker_if.slave u
);
  localparam int IW = $clog2(NUM_VALS) < 1 ? 1 : $clog2(NUM_VALS);
  localparam logic [IW-1:0] LAST = IW'(NUM_VALS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [NUM_VALS*SIZE-1:0] frame;
  logic [SIZE-1:0] prev;
  logic [SIZE-1:0] nxt_data;
  logic [IW-1:0] nxt_idx;
  logic xfer;
  assign xfer = u.out_valid & u.out_ready;
  assign nxt_idx = u.out_idx + 1'b1;
  assign nxt_data = frame[nxt_idx*SIZE +: SIZE];
  assign u.in_ready = state == IDLE;
  // out_data always equals frame[idx], so the flag is stable whenever the element is
  assign u.out_order_err = (u.out_idx != '0) && (u.out_data > prev);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      frame <= '0;
      prev <= '0;
      u.order_err_sticky <= 1'b0;
      u.out_valid <= 1'b0;
      u.out_data <= '0;
      u.out_idx <= '0;
      u.out_first <= 1'b0;
      u.out_last <= 1'b0;
    end else if (state == IDLE) begin
      if (u.in_valid) begin
        state <= SEND;
        frame <= u.in_bus;
        u.out_valid <= 1'b1;
        u.out_data <= u.in_bus[SIZE-1:0];
        u.out_idx <= '0;
        u.out_first <= 1'b1;
        u.out_last <= 1'b0;
      end
    end else if (xfer) begin
      prev <= u.out_data;
      u.order_err_sticky <= u.order_err_sticky | u.out_order_err;
      if (u.out_last) begin
        state <= IDLE;
        u.out_valid <= 1'b0;
        u.out_data <= '0;
        u.out_idx <= '0;
        u.out_first <= 1'b0;
        u.out_last <= 1'b0;
      end else begin
        u.out_data <= nxt_data;
        u.out_idx <= nxt_idx;
        u.out_first <= 1'b0;
        u.out_last <= nxt_idx == LAST;
      end
    end
  end
endmodule

// File: tb/tb_sort_unpacker.sv
// tb_sort_unpacker: directed frames with a queue scoreboard checked by an output monitor.
module tb_sort_unpacker;
  localparam int N = 9;
  localparam int W = 8;
  typedef logic [W-1:0] fr_t [N];
  typedef struct packed {logic [7:0] d; logic [3:0] i; logic f; logic l; logic e;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int xfers = 0;
  exp_t sb[$];
  exp_t snap;
  exp_t ex;
  logic exp_sticky = 1'b0;
  logic stalled = 1'b0;
  sort_unpacker_if #(.NUM_VALS(N), .SIZE(W)) u();
  sort_unpacker #(.NUM_VALS(N), .SIZE(W)) dut (.clk(clk), .rst_n(rst_n), .u(u));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t cur();
    return {u.out_data, u.out_idx, u.out_first, u.out_last, u.out_order_err};
  endfunction
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      exp_sticky = 1'b0;
    end else begin
      chk("sticky", u.order_err_sticky, exp_sticky);
      if (!u.out_valid) chk("idle_zero", cur(), 0);
      if (stalled && u.out_valid) chk("hold", cur(), snap);
      if (u.out_valid && u.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none", cur());
        end else begin
          ex = sb.pop_front();
          chk("out", cur(), ex);
          xfers++;
          if (ex.e) exp_sticky = 1'b1;
        end
      end
      stalled = u.out_valid && !u.out_ready;
      snap = cur();
    end
  end
  task automatic drive(input fr_t v);
    for (int k = 0; k < N; k++) u.in_bus[k*W +: W] = v[k];
  endtask
  task automatic expect_frame(input fr_t v);
    logic e;
    for (int k = 0; k < N; k++) begin
      e = 1'b0;
      if (k > 0) e = v[k] > v[k-1];
      sb.push_back({v[k], 4'(k), k == 0, k == N - 1, e});
    end
  endtask
  task automatic offer(input fr_t v);
    logic ok;
    int c;
    drive(v);
    u.in_valid = 1'b1;
    expect_frame(v);
    for (c = 0; c < 50; c++) begin
      ok = u.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (c == 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept");
    end
    u.in_valid = 1'b0;
  endtask
  task automatic drain(input bit toggle);
    int c;
    for (c = 0; c < 200; c++) begin
      if (sb.size() == 0 && u.in_ready && !u.out_valid) break;
      if (toggle) u.out_ready = !u.out_ready;
      @(posedge clk);
      #1;
    end
    if (c == 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    u.out_ready = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    fr_t f1, f3, fff, v;
    int x0, last;
    f1 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    f3 = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd10, 8'd4, 8'd3, 8'd2, 8'd1};
    for (int k = 0; k < N; k++) fff[k] = 8'hFF;
    u.in_valid = 1'b0;
    u.in_bus = '0;
    u.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_in_ready", u.in_ready, 1);
    chk("rst_out_valid", u.out_valid, 0);
    chk("rst_sticky", u.order_err_sticky, 0);
    offer(f1);
    chk("lat_valid", u.out_valid, 1);
    chk("lat_data", u.out_data, 9);
    chk("lat_first", u.out_first, 1);
    chk("send_in_ready", u.in_ready, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("last_flag", u.out_last, 1);
    chk("last_data", u.out_data, 1);
    chk("last_in_ready", u.in_ready, 0);
    @(posedge clk);
    #1;
    chk("end_in_ready", u.in_ready, 1);
    chk("end_out_valid", u.out_valid, 0);
    drain(0);
    chk("clean_sticky", u.order_err_sticky, 0);
    x0 = xfers;
    offer(f1);
    drain(1);
    chk("toggle_xfers", xfers - x0, 9);
    offer(f3);
    drain(0);
    chk("err_sticky", u.order_err_sticky, 1);
    offer(f1);
    drain(0);
    chk("sticky_persist", u.order_err_sticky, 1);
    offer(fff);
    drain(0);
    offer(f1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_idx", u.out_idx, 3);
    rst_n = 1'b0;
    u.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    u.out_ready = 1'b1;
    sb.delete();
    chk("mid_rst_valid", u.out_valid, 0);
    chk("mid_rst_in_ready", u.in_ready, 1);
    chk("mid_rst_sticky", u.order_err_sticky, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abandoned_valid", u.out_valid, 0);
    offer(f1);
    drain(0);
    drive(f3);
    u.in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    u.in_valid = 1'b0;
    chk("rst_capture_valid", u.out_valid, 0);
    @(posedge clk);
    #1;
    chk("rst_capture_late", u.out_valid, 0);
    last = -1;
    u.in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < N; k++) v[k] = 8'(c * 3 + N - k);
      drive(v);
      if (u.in_ready) begin
        expect_frame(v);
        if (last >= 0) chk("period", c - last, 10);
        last = c;
      end
      @(posedge clk);
      #1;
    end
    u.in_valid = 1'b0;
    drain(0);
    chk("final_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sort_unpacker.md
SORT_UNPACKER -- requirements
Module: sort_unpacker

Interface
REQ-001 Parameter NUM_VALS, default 9: number of elements per frame; legal range 2..64.
REQ-002 Parameter SIZE, default 8: element width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  packed frame on in_bus offered this cycle.
REQ-006 in_ready  output  1  block accepts a frame this cycle.
REQ-007 in_bus  input  NUM_VALS*SIZE  packed frame; element k = in_bus[k*SIZE +: SIZE], element 0 is the largest value of a descending-sorted frame.
REQ-008 out_valid  output  1  out_data holds a valid element.
REQ-009 out_ready  input  1  downstream accepts the element this cycle.
REQ-010 out_data  output  SIZE  current element.
REQ-011 out_idx  output  max(1,$clog2(NUM_VALS))  index k of current element.
REQ-012 out_first  output  1  current element is index 0.
REQ-013 out_last  output  1  current element is index NUM_VALS-1.
REQ-014 out_order_err  output  1  current element is larger than the element emitted before it in the same frame.
REQ-015 order_err_sticky  output  1  set on any emitted element with out_order_err=1; cleared only by reset.

Function
REQ-016 FSM states: IDLE, SEND; reset state IDLE.
REQ-017 in_ready SHALL equal 1 in IDLE and 0 in SEND, decoded from registered state only (no combinational path from out_ready).
REQ-018 IDLE, in_valid=1: capture in_bus into an internal frame register, idx<=0, go to SEND; in_valid=0: stay IDLE.
REQ-019 SEND: out_valid=1, out_data=frame[idx], out_idx=idx, out_first=(idx==0), out_last=(idx==NUM_VALS-1).
REQ-020 Latency: first element is presented the cycle after the accepting in_valid&in_ready edge.
REQ-021 Element transfer occurs on out_valid&out_ready; idx increments by 1 on each transfer except the last.
REQ-022 Transfer with idx==NUM_VALS-1: go to IDLE; out_valid=0 next cycle; minimum frame period NUM_VALS+1 cycles.
REQ-023 Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx, out_first, out_last, out_order_err SHALL hold stable.
REQ-024 in_bus changes while in SEND SHALL NOT affect the frame being emitted.
REQ-025 Previous-element register updated on each transfer; out_order_err = (idx!=0) and (frame[idx] > previous), unsigned compare; always 0 when idx==0.
REQ-026 order_err_sticky sets on the transfer edge of an element with out_order_err=1; remains 1 across frames.
REQ-027 Equal adjacent values SHALL NOT flag out_order_err.
REQ-028 out_valid=0 in IDLE; out_data, out_idx, out_first, out_last, out_order_err are don't-care when out_valid=0 but SHALL be driven to 0.

Reset
REQ-029 rst_n=0 at a rising edge: state<=IDLE, idx<=0, frame and previous-element registers <=0, order_err_sticky<=0, all outputs 0 except in_ready=1 on the following cycle.
REQ-030 Reset during SEND SHALL abandon the frame; no further elements of it emitted after reset deasserts.
REQ-031 in_valid asserted in the cycle rst_n=0 SHALL NOT be captured.

Verification
REQ-032 Frame {9,8,7,6,5,4,3,2,1} (element 0 = 9), out_ready=1 held -> out_data 9..1 on 9 consecutive cycles starting cycle after accept, out_first on 9, out_last on 1, in_ready=1 again on cycle 11, sticky=0.
REQ-033 Same frame, out_ready toggling 1,0,1,0 -> each element held stable during out_ready=0, exactly 9 transfers, order preserved.
REQ-034 Frame {9,8,7,6,10,4,3,2,1} -> out_order_err=1 only with element 10 (idx 4), order_err_sticky=1 from following cycle and persists through a following clean frame.
REQ-035 Frame of all 8'hFF -> no out_order_err; all 9 elements emitted as 8'hFF.
REQ-036 rst_n=0 for one cycle while idx=3 in SEND -> next cycle out_valid=0, in_ready=1, sticky=0; next frame starts at idx 0.
REQ-037 in_valid held high continuously with changing in_bus -> frames accepted only in IDLE cycles, each emitted frame equals in_bus at its accept edge, frame period 10 cycles.
